gat_load_ctrl: RTL and testbench
================================

GAT_LOAD_CTRL -- requirements
Module: gat_load_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter TOP_WIDTH, default 32, host word width.
REQ-003 Parameter H_DATA_DEPTH, default 242101, H data words loaded.
REQ-004 Parameter NODE_INFO_DEPTH, default 13264, node-info words loaded.
REQ-005 Parameter WEIGHT_DEPTH, default 22928, weight words loaded.
REQ-006 Parameter SUBGRAPH_IDX_DEPTH, default 13264, subgraph-index words loaded.
REQ-007 Parameter NEW_FEATURE_DEPTH, default 43328, feature words read back.
REQ-008 Parameter FEAT_RD_LAT, default 2, feature BRAM read latency in cycles.
REQ-009 Derived widths SHALL be X_ADDR_W = $clog2(X_DEPTH) for each depth; byte addresses are X_ADDR_W+2 bits.
REQ-010 clk  in  1  clock.
REQ-011 rst  in  1  synchronous active-high reset.
REQ-012 start  in  1  one-cycle pulse; begins a load/run/readout job.
REQ-013 s_data  in  TOP_WIDTH  host load word.
REQ-014 s_valid  in  1  s_data valid.
REQ-015 s_ready  out  1  block accepts s_data.
REQ-016 h_data_bram_{din,ena,wea,addra}  out  TOP_WIDTH,1,1,H_DATA_ADDR_W+2  H data BRAM write port.
REQ-017 h_node_info_bram_{din,ena,wea,addra}  out  TOP_WIDTH,1,1,NODE_INFO_ADDR_W+2  node-info BRAM write port.
REQ-018 wgt_bram_{din,ena,wea,addra}  out  TOP_WIDTH,1,1,WEIGHT_ADDR_W+2  weight BRAM write port.
REQ-019 subgraph_bram_{din,ena,wea,addra}  out  TOP_WIDTH,1,1,SUBGRAPH_IDX_ADDR_W+2  subgraph BRAM write port.
REQ-020 h_data_bram_load_done / h_node_info_bram_load_done / wgt_bram_load_done  out  1 each  sticky region-loaded flags.
REQ-021 gat_ready  in  1  accelerator finished.
REQ-022 feat_bram_addrb  out  NEW_FEATURE_ADDR_W+2  feature BRAM byte read address.
REQ-023 feat_bram_dout  in  32  feature BRAM read data, valid FEAT_RD_LAT cycles after address.
REQ-024 m_data / m_valid / m_ready / m_last  out/out/in/out  32/1/1/1  result stream.
REQ-025 busy / done  out  1 each  job active / one-cycle job-complete pulse.

Function
REQ-026 FSM states SHALL be IDLE, LD_SUB, LD_H, LD_INFO, LD_WGT, WAIT_GAT, READ, FINISH; start in IDLE -> LD_SUB; start outside IDLE ignored.
REQ-027 Load order SHALL be subgraph, H data, node info, weight; each LD_* state accepts exactly its DEPTH words, then moves to the next state the cycle after the last beat.
REQ-028 s_ready SHALL be 1 only in LD_* states; a beat is s_valid&s_ready; each beat drives that BRAM's din=s_data, ena=wea=1 in the same cycle, combinationally; ena/wea 0 otherwise.
REQ-029 addra SHALL be 4*word_index, starting at 0 per region, incrementing by 4 per beat; no wrap within a job.
REQ-030 Each load_done flag SHALL rise the cycle after its region's last beat and hold until the next accepted start or reset.
REQ-031 WAIT_GAT SHALL sample gat_ready only after entering the state; gat_ready=1 -> READ next cycle.
REQ-032 READ SHALL issue feature read addresses 0,4,... one per cycle, only when (output buffer occupancy + reads in flight) < FEAT_RD_LAT+2; buffer depth FEAT_RD_LAT+2, no data loss under any m_ready pattern.
REQ-033 m_valid SHALL be 1 when buffer non-empty; m_last=1 on word NEW_FEATURE_DEPTH-1 only; m_data stable while m_valid&!m_ready.
REQ-034 After the last-word handshake the FSM SHALL enter FINISH, pulse done for one cycle, return to IDLE.
REQ-035 busy SHALL be 1 in every state except IDLE.

Reset
REQ-036 rst=1 at any cycle, including mid-load or mid-readout, SHALL next cycle force IDLE, clear counters, buffer and in-flight reads, and drive all outputs 0 (addresses 0, flags 0, s_ready 0, m_valid 0, done 0).

Verification
REQ-037 Depths overridden to 3,2,2,1,5: start, continuous s_valid words 1..8 -> subgraph addr 0 data 1; H addr 0,4,8 data 2,3,4; info 5,6; wgt 7,8; flags rise in order.
REQ-038 s_valid toggling each cycle -> write only on handshakes, addresses contiguous, no skipped or duplicated words.
REQ-039 gat_ready held high before start -> no READ before all loads complete; then 5 words on m_data with m_last on 5th, done pulse one cycle later.
REQ-040 m_ready low 10 cycles during READ -> reads stall at 4 buffered+in-flight, all 5 words delivered in order.
REQ-041 rst asserted after 2 H data beats -> all outputs 0 next cycle; new start reloads from address 0.
REQ-042 start pulsed during LD_H -> ignored; job continues unchanged.

Source files
------------

// File: rtl/gat_load_ctrl.sv
// gat_load_ctrl: streams host words into four BRAM regions, waits for the accelerator, then reads features back as a stream.
module gat_load_ctrl #(
  parameter int TOP_WIDTH = 32,
  parameter int H_DATA_DEPTH = 242101,
  parameter int NODE_INFO_DEPTH = 13264,
  parameter int WEIGHT_DEPTH = 22928,
  parameter int SUBGRAPH_IDX_DEPTH = 13264,
  parameter int NEW_FEATURE_DEPTH = 43328,
  parameter int FEAT_RD_LAT = 2,
  localparam int H_DATA_ADDR_W = $clog2(H_DATA_DEPTH),
  localparam int NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH),
  localparam int WEIGHT_ADDR_W = $clog2(WEIGHT_DEPTH),
  localparam int SUBGRAPH_IDX_ADDR_W = $clog2(SUBGRAPH_IDX_DEPTH),
  localparam int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  localparam int HB = H_DATA_ADDR_W + 2,
  localparam int IB = NODE_INFO_ADDR_W + 2,
  localparam int WB = WEIGHT_ADDR_W + 2,
  localparam int SB = SUBGRAPH_IDX_ADDR_W + 2,
  localparam int NB = NEW_FEATURE_ADDR_W + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [TOP_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [TOP_WIDTH-1:0] h_data_bram_din,
  output logic                 h_data_bram_ena,
  output logic                 h_data_bram_wea,
  output logic [HB-1:0]        h_data_bram_addra,
  output logic [TOP_WIDTH-1:0] h_node_info_bram_din,
  output logic                 h_node_info_bram_ena,
  output logic                 h_node_info_bram_wea,
  output logic [IB-1:0]        h_node_info_bram_addra,
  output logic [TOP_WIDTH-1:0] wgt_bram_din,
  output logic                 wgt_bram_ena,
  output logic                 wgt_bram_wea,
  output logic [WB-1:0]        wgt_bram_addra,
  output logic [TOP_WIDTH-1:0] subgraph_bram_din,
  output logic                 subgraph_bram_ena,
  output logic                 subgraph_bram_wea,
  output logic [SB-1:0]        subgraph_bram_addra,
  output logic                 h_data_bram_load_done,
  output logic                 h_node_info_bram_load_done,
  output logic                 wgt_bram_load_done,
  input  logic                 gat_ready,
  output logic [NB-1:0]        feat_bram_addrb,
  input  logic [31:0]          feat_bram_dout,
  output logic [31:0]          m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);
  localparam int D = FEAT_RD_LAT + 2;
  localparam int PW = $clog2(D);
  localparam int CW = $clog2(D + 1);
  typedef enum logic [2:0] {IDLE, LD_SUB, LD_H, LD_INFO, LD_WGT, WAIT_GAT, READ, FINISH} state_t;
  state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d, rd_q, rd_d, out_q, out_d, depth;
  logic h_done_q, h_done_d, info_done_q, info_done_d, wgt_done_q, wgt_done_d;
  logic [FEAT_RD_LAT-1:0] pipe_q, pipe_d;
  logic [31:0] buf_q [D];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] occ_q, occ_d, inflight;
  logic ld, beat, last_beat, issue, cap, pop, last_out, clr;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(D - 1) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    ld = state_q inside {LD_SUB, LD_H, LD_INFO, LD_WGT};
    beat = ld & s_valid;
    depth = state_q == LD_SUB ? 32'(SUBGRAPH_IDX_DEPTH) : state_q == LD_H ? 32'(H_DATA_DEPTH) :
            state_q == LD_INFO ? 32'(NODE_INFO_DEPTH) : 32'(WEIGHT_DEPTH);
    last_beat = beat && cnt_q == depth - 32'd1;
    inflight = '0;
    for (int i = 0; i < FEAT_RD_LAT; i++) inflight = inflight + CW'(pipe_q[i]);
    cap = pipe_q[FEAT_RD_LAT-1];
    pop = m_valid & m_ready;
    // buffered plus in-flight words never exceed the buffer, so m_ready stalls cannot drop data
    issue = state_q == READ && rd_q < 32'(NEW_FEATURE_DEPTH) && 32'(occ_q) + 32'(inflight) < 32'(D);
    last_out = pop && out_q == 32'(NEW_FEATURE_DEPTH - 1);
    clr = state_q == IDLE && start;
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = LD_SUB;
      LD_SUB:   if (last_beat) state_d = LD_H;
      LD_H:     if (last_beat) state_d = LD_INFO;
      LD_INFO:  if (last_beat) state_d = LD_WGT;
      LD_WGT:   if (last_beat) state_d = WAIT_GAT;
      WAIT_GAT: if (gat_ready) state_d = READ;
      READ:     if (last_out) state_d = FINISH;
      default:  state_d = IDLE;
    endcase
    cnt_d = last_beat ? '0 : cnt_q + 32'(beat);
    rd_d = state_q == FINISH ? '0 : rd_q + 32'(issue);
    out_d = state_q == FINISH ? '0 : out_q + 32'(pop);
    occ_d = occ_q + CW'(cap) - CW'(pop);
    pipe_d = FEAT_RD_LAT'({pipe_q, issue});
    h_done_d = !clr && (h_done_q || (state_q == LD_H && last_beat));
    info_done_d = !clr && (info_done_q || (state_q == LD_INFO && last_beat));
    wgt_done_d = !clr && (wgt_done_q || (state_q == LD_WGT && last_beat));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rd_q <= '0;
      out_q <= '0;
      pipe_q <= '0;
      occ_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      h_done_q <= 1'b0;
      info_done_q <= 1'b0;
      wgt_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      out_q <= out_d;
      pipe_q <= pipe_d;
      occ_q <= occ_d;
      wp_q <= cap ? inc(wp_q) : wp_q;
      rp_q <= pop ? inc(rp_q) : rp_q;
      h_done_q <= h_done_d;
      info_done_q <= info_done_d;
      wgt_done_q <= wgt_done_d;
    end
  end
  always_ff @(posedge clk) if (cap) buf_q[wp_q] <= feat_bram_dout;
  assign s_ready = ld;
  assign subgraph_bram_ena = beat && state_q == LD_SUB;
  assign subgraph_bram_wea = subgraph_bram_ena;
  assign subgraph_bram_din = subgraph_bram_ena ? s_data : '0;
  assign subgraph_bram_addra = state_q == LD_SUB ? SB'({cnt_q, 2'b00}) : '0;
  assign h_data_bram_ena = beat && state_q == LD_H;
  assign h_data_bram_wea = h_data_bram_ena;
  assign h_data_bram_din = h_data_bram_ena ? s_data : '0;
  assign h_data_bram_addra = state_q == LD_H ? HB'({cnt_q, 2'b00}) : '0;
  assign h_node_info_bram_ena = beat && state_q == LD_INFO;
  assign h_node_info_bram_wea = h_node_info_bram_ena;
  assign h_node_info_bram_din = h_node_info_bram_ena ? s_data : '0;
  assign h_node_info_bram_addra = state_q == LD_INFO ? IB'({cnt_q, 2'b00}) : '0;
  assign wgt_bram_ena = beat && state_q == LD_WGT;
  assign wgt_bram_wea = wgt_bram_ena;
  assign wgt_bram_din = wgt_bram_ena ? s_data : '0;
  assign wgt_bram_addra = state_q == LD_WGT ? WB'({cnt_q, 2'b00}) : '0;
  assign h_data_bram_load_done = h_done_q;
  assign h_node_info_bram_load_done = info_done_q;
  assign wgt_bram_load_done = wgt_done_q;
  assign feat_bram_addrb = NB'({rd_q, 2'b00});
  assign m_valid = occ_q != '0;
  assign m_data = m_valid ? buf_q[rp_q] : '0;
  assign m_last = m_valid && out_q == 32'(NEW_FEATURE_DEPTH - 1);
  assign busy = state_q != IDLE;
  assign done = state_q == FINISH;
endmodule

// File: tb/tb_gat_load_ctrl.sv
// tb_gat_load_ctrl: table vectors, hand sequences and random jobs against a region/stream reference model.
module tb_gat_load_ctrl;
  localparam int HD = 3, ID = 2, WD = 2, SD = 1, NF = 5, LAT = 2;
  localparam int HB = $clog2(HD) + 2, IB = $clog2(ID) + 2, WB = $clog2(WD) + 2;
  localparam int SB = $clog2(SD) + 2, NB = $clog2(NF) + 2;
  logic clk = 0, rst = 1, start = 0, s_valid = 0, s_ready, gat_ready = 0, m_ready = 0;
  logic [31:0] s_data = 0;
  logic [31:0] h_din, i_din, w_din, sg_din, feat_bram_dout, m_data;
  logic h_ena, h_wea, i_ena, i_wea, w_ena, w_wea, sg_ena, sg_wea;
  logic [HB-1:0] h_addr;
  logic [IB-1:0] i_addr;
  logic [WB-1:0] w_addr;
  logic [SB-1:0] sg_addr;
  logic [NB-1:0] feat_bram_addrb, a1 = 0, a2 = 0;
  logic h_fl, i_fl, w_fl, m_valid, m_last, busy, done;

  gat_load_ctrl #(.H_DATA_DEPTH(HD), .NODE_INFO_DEPTH(ID), .WEIGHT_DEPTH(WD),
    .SUBGRAPH_IDX_DEPTH(SD), .NEW_FEATURE_DEPTH(NF), .FEAT_RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .h_data_bram_din(h_din), .h_data_bram_ena(h_ena), .h_data_bram_wea(h_wea), .h_data_bram_addra(h_addr),
    .h_node_info_bram_din(i_din), .h_node_info_bram_ena(i_ena), .h_node_info_bram_wea(i_wea),
    .h_node_info_bram_addra(i_addr),
    .wgt_bram_din(w_din), .wgt_bram_ena(w_ena), .wgt_bram_wea(w_wea), .wgt_bram_addra(w_addr),
    .subgraph_bram_din(sg_din), .subgraph_bram_ena(sg_ena), .subgraph_bram_wea(sg_wea),
    .subgraph_bram_addra(sg_addr),
    .h_data_bram_load_done(h_fl), .h_node_info_bram_load_done(i_fl), .wgt_bram_load_done(w_fl),
    .gat_ready(gat_ready), .feat_bram_addrb(feat_bram_addrb), .feat_bram_dout(feat_bram_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] feat(input int i);
    return 32'hC0DE0000 + 32'(i) * 32'h111;
  endfunction
  always @(posedge clk) begin
    a1 <= feat_bram_addrb;
    a2 <= a1;
  end
  assign feat_bram_dout = feat(int'(a2 >> 2));

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {int r; int a; logic [31:0] d;} wr_t;
  typedef struct {logic [31:0] d; logic l;} ot_t;
  typedef struct {logic [31:0] din; int r; int a;} vec_t;
  wr_t wrs[$];
  ot_t outs[$];
  vec_t tab[8];
  int rise[4];
  int done_n, done_cyc, last_cyc, first_mv;
  logic stall_prev = 0;
  logic [31:0] data_prev;
  logic [2:0] fl_prev = 0;

  always @(negedge clk) begin
    if (sg_ena && sg_wea) wrs.push_back('{0, int'(sg_addr), sg_din});
    if (h_ena && h_wea) wrs.push_back('{1, int'(h_addr), h_din});
    if (i_ena && i_wea) wrs.push_back('{2, int'(i_addr), i_din});
    if (w_ena && w_wea) wrs.push_back('{3, int'(w_addr), w_din});
    if (stall_prev) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, data_prev);
    end
    stall_prev = m_valid && !m_ready && !rst;
    data_prev = m_data;
    if (m_valid && m_ready) begin
      outs.push_back('{m_data, m_last});
      if (m_last) last_cyc = cyc;
    end
    if (m_valid && first_mv < 0) first_mv = cyc;
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (h_fl && !fl_prev[0]) rise[1] = cyc;
    if (i_fl && !fl_prev[1]) rise[2] = cyc;
    if (w_fl && !fl_prev[2]) rise[3] = cyc;
    fl_prev = {w_fl, i_fl, h_fl};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // vm: 0 continuous / 1 toggling / 2 random s_valid; rm: 0 always / 1 ten-cycle stall / 2 random m_ready
  task automatic run_job(input int vm, input int rm, input bit gat_early, input bit mid_start, input bit use_tab);
    logic [31:0] w[8];
    int bc[8];
    int base[5];
    int j, k, r;
    base = '{0, SD, SD + HD, SD + HD + ID, SD + HD + ID + WD};
    for (int i = 0; i < 8; i++) w[i] = use_tab ? tab[i].din : $urandom;
    wrs.delete();
    outs.delete();
    rise = '{-1, -1, -1, -1};
    done_n = 0; done_cyc = -1; last_cyc = -1; first_mv = -1;
    gat_ready = gat_early;
    m_ready = rm == 0;
    start = 1;
    step();
    j = 0; k = 0;
    while (j < 8) begin
      s_valid = vm == 0 ? 1'b1 : vm == 1 ? k % 2 == 0 : 1'($urandom_range(0, 1));
      s_data = s_valid ? w[j] : $urandom;
      start = mid_start && s_valid && j == 3;
      @(negedge clk);
      if (k == 0) begin
        chk("flags_cleared", {w_fl, i_fl, h_fl}, 0);
        chk("busy_load", busy, 1);
      end
      if (s_valid) begin
        chk("s_ready_load", s_ready, 1);
        bc[j] = cyc;
        j++;
      end
      k++;
      step();
    end
    s_valid = 0; s_data = 0; start = 0;
    if (!gat_early) begin
      repeat (3) begin
        @(negedge clk);
        chk("no_read_wait", m_valid, 0);
        chk("busy_wait", busy, 1);
        step();
      end
      gat_ready = 1;
    end
    for (int t = 0; t < 400 && done_n == 0; t++) begin
      m_ready = rm == 0 ? 1'b1 : rm == 1 ? t >= 12 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (rm == 1 && t == 11) begin
        chk("stall_addr", feat_bram_addrb, 4 * (LAT + 2));
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, feat(0));
      end
      step();
    end
    chk("done_seen", done_n, 1);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("wr_count", wrs.size(), 8);
    for (int i = 0; i < 8 && i < wrs.size(); i++) begin
      r = i < base[1] ? 0 : i < base[2] ? 1 : i < base[3] ? 2 : 3;
      chk("wr_region", wrs[i].r, use_tab ? tab[i].r : r);
      chk("wr_addr", wrs[i].a, use_tab ? tab[i].a : 4 * (i - base[r]));
      chk("wr_data", wrs[i].d, w[i]);
    end
    chk("rise_h", rise[1], bc[base[2] - 1] + 1);
    chk("rise_info", rise[2], bc[base[3] - 1] + 1);
    chk("rise_wgt", rise[3], bc[7] + 1);
    chk("out_count", outs.size(), NF);
    for (int i = 0; i < NF && i < outs.size(); i++) begin
      chk("out_data", outs[i].d, feat(i));
      chk("out_last", outs[i].l, i == NF - 1);
    end
    chk("done_timing", done_cyc, last_cyc + 1);
    chk("read_after_load", first_mv > rise[3], 1);
    chk("flags_hold", {w_fl, i_fl, h_fl}, 3'b111);
    gat_ready = 0;
    m_ready = 0;
    step();
  endtask

  task automatic reset_mid();
    start = 1;
    step();
    start = 0;
    s_valid = 1;
    for (int i = 0; i < 3; i++) begin
      s_data = 32'h100 + i;
      step();
    end
    s_valid = 0;
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("rst_busy_ready", {busy, s_ready, done, m_valid}, 0);
    chk("rst_flags", {w_fl, i_fl, h_fl}, 0);
    chk("rst_ena", {h_ena, h_wea, i_ena, i_wea, w_ena, w_wea, sg_ena, sg_wea}, 0);
    chk("rst_addr", {h_addr, i_addr, w_addr, sg_addr, feat_bram_addrb}, 0);
    chk("rst_data", m_data | h_din | i_din | w_din | sg_din, 0);
    step();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      tab[i].din = 32'(i + 1);
      tab[i].r = i < 1 ? 0 : i < 4 ? 1 : i < 6 ? 2 : 3;
      tab[i].a = i < 1 ? 0 : i < 4 ? 4 * (i - 1) : i < 6 ? 4 * (i - 4) : 4 * (i - 6);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("reset_ctl", {busy, s_ready, done, m_valid, m_last}, 0);
    chk("reset_flags", {w_fl, i_fl, h_fl}, 0);
    chk("reset_addrb", feat_bram_addrb, 0);
    step();
    run_job(0, 0, 1, 0, 1);
    run_job(1, 1, 0, 0, 0);
    run_job(0, 0, 0, 1, 0);
    reset_mid();
    run_job(0, 0, 1, 0, 0);
    for (int n = 0; n < 6; n++) run_job(2, 2, 1'($urandom_range(0, 1)), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
